// File: rtl/mio_arb_pkg.sv
// mio_arb_pkg: shared types and constants for the MIO bus arbiter.
// Holds the arbiter state encoding, default sizing for the watchdog,
// requester indices and the fixed-priority grant helper.
package mio_arb_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_CNT_W       = 8;

  // Requester indices into grant vectors
  localparam int REQ_IF  = 0;
  localparam int REQ_DM  = 1;
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_e;

  // Data memory wins over fetch: the MEM-stage access belongs to the older
  // instruction, so serving it first keeps the pipeline draining in order.
  function automatic logic [NUM_REQ-1:0] pick_grant(input logic if_req,
                                                    input logic dm_req);
    logic [NUM_REQ-1:0] g;
    g = '0;
    if (dm_req) begin
      g[REQ_DM] = 1'b1;
    end else if (if_req) begin
      g[REQ_IF] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mio_bus_arbiter_if.sv
// mio_bus_arbiter_if: requester handshakes plus the external MIO bus.
// The master modport is the arbiter's view (it masters the MIO bus);
// the slave modport is the environment: pipeline stages and memory system.
interface mio_bus_arbiter_if #(
  parameter int DATA_W = 32
);

  // Instruction-fetch requester
  logic              if_req;
  logic [DATA_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  // Data-memory requester
  logic              dm_req;
  logic              dm_we;
  logic [DATA_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              bus_err;

  // External MIO bus
  logic              MIO_ready;
  logic [DATA_W-1:0] Data_in;
  logic              CPU_MIO;
  logic              mem_w;
  logic [DATA_W-1:0] Addr_out;
  logic [DATA_W-1:0] Data_out;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  MIO_ready, Data_in,
    output if_rdata, if_ack, dm_rdata, dm_ack, bus_err,
    output CPU_MIO, mem_w, Addr_out, Data_out
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output MIO_ready, Data_in,
    input  if_rdata, if_ack, dm_rdata, dm_ack, bus_err,
    input  CPU_MIO, mem_w, Addr_out, Data_out
  );

endinterface

// File: rtl/mio_wdog_cnt.sv
// mio_wdog_cnt: busy-cycle watchdog for the MIO arbiter.
// Counts enabled cycles since the last clear and flags the cycle whose
// closing edge would bring the count up to LIMIT.
module mio_wdog_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic limit_hit
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count;

  // Count stalled busy cycles; clear wins so every access starts from zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign limit_hit = enable && !clear && (count == LAST);

endmodule

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares the single MIO port between instruction fetch
// and data memory. Data memory has priority, accesses are never preempted,
// and each completed access returns one registered one-cycle ack.
// Optional feature macro: MIO_TIMEOUT_EN adds a busy-cycle watchdog that
// aborts a stuck access with bus_err; without it bus_err is tied low and
// a busy state waits for MIO_ready indefinitely.
module mio_bus_arbiter
  import mio_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  mio_bus_arbiter_if.master bus
);

  // Elaboration-time sanity check of the watchdog sizing
  if ((2 ** CNT_W) <= TIMEOUT_CYC) begin : g_cfg_check
    $error("mio_bus_arbiter: CNT_W is too narrow for TIMEOUT_CYC");
  end

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              mem_w_q, mem_w_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [NUM_REQ-1:0] gnt;

  // A requester acked this cycle is still holding req; mask it so the
  // stale request is not granted a second time.
  assign gnt = pick_grant(bus.if_req && !if_ack_q, bus.dm_req && !dm_ack_q);

`ifdef MIO_TIMEOUT_EN
  logic busy;
  logic timeout_hit;
  logic err_q, err_d;

  assign busy = (state_q != IDLE);

  mio_wdog_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear     (!busy),
    .enable    (busy && !bus.MIO_ready),
    .limit_hit (timeout_hit)
  );
`endif

  // Next-state and next-output logic: grant in IDLE, complete in BUSY
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mem_w_d    = mem_w_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
`ifdef MIO_TIMEOUT_EN
    err_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt[REQ_DM]) begin
          addr_d  = bus.dm_addr;
          wdata_d = bus.dm_wdata;
          mem_w_d = bus.dm_we;
          state_d = DM_BUSY;
        end else if (gnt[REQ_IF]) begin
          addr_d  = bus.if_addr;
          mem_w_d = 1'b0;
          state_d = IF_BUSY;
        end
      end
      IF_BUSY: begin
        if (bus.MIO_ready) begin
          if_rdata_d = bus.Data_in;
          if_ack_d   = 1'b1;
          mem_w_d    = 1'b0;
          state_d    = IDLE;
        end
`ifdef MIO_TIMEOUT_EN
        else if (timeout_hit) begin
          if_ack_d = 1'b1;
          err_d    = 1'b1;
          mem_w_d  = 1'b0;
          state_d  = IDLE;
        end
`endif
      end
      DM_BUSY: begin
        if (bus.MIO_ready) begin
          if (!mem_w_q) begin
            dm_rdata_d = bus.Data_in;
          end
          dm_ack_d = 1'b1;
          mem_w_d  = 1'b0;
          state_d  = IDLE;
        end
`ifdef MIO_TIMEOUT_EN
        else if (timeout_hit) begin
          dm_ack_d = 1'b1;
          err_d    = 1'b1;
          mem_w_d  = 1'b0;
          state_d  = IDLE;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        mem_w_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight access at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_w_q    <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_w_q    <= mem_w_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
    end
  end

`ifdef MIO_TIMEOUT_EN
  // Abort flag register, pulses alongside the ack of a timed-out access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.bus_err = err_q;
`else
  assign bus.bus_err = 1'b0;
`endif

  assign bus.CPU_MIO  = (state_q != IDLE);
  assign bus.mem_w    = mem_w_q;
  assign bus.Addr_out = addr_q;
  assign bus.Data_out = wdata_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: scoreboard bench for mio_bus_arbiter.
// Requester tasks push the expected completion (rdata, bus_err) of every
// access into a per-requester queue; a negedge monitor pops on each ack.
// A memory responder plays the MIO bus and checks the presented address,
// write strobe and write data against what the requesters asked for.
module tb_mio_bus_arbiter;
  import mio_arb_pkg::*;

  localparam int DW = 32;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int total = 0;
  int bad   = 0;

  exp_t        if_q[$];
  exp_t        dm_q[$];
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] bus_mem [0:1023];
  logic [31:0] if_last = '0;
  logic [31:0] dm_last = '0;

  logic [31:0] if_cur_addr = '0;
  logic [31:0] dm_cur_addr = '0;
  logic [31:0] dm_cur_wdata = '0;
  logic        dm_cur_we = 1'b0;
  bit          dm_active = 1'b0;

  int fixed_wait = 0;
  bit hang = 1'b0;
  bit noise = 1'b0;

  always #5 clk = ~clk;

  mio_bus_arbiter_if #(.DATA_W(DW)) bus ();

  mio_bus_arbiter #(
    .DATA_W      (DW),
    .TIMEOUT_CYC (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (model_mem.exists(a)) return model_mem[a];
    return init_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s actual=event required=none t=%0t", name, $time);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raise a request and record what its completion must look like
  task automatic applyStimulus(input int who, input bit we,
                               input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.err = hang;
    if (who == REQ_IF) begin
      bus.if_req  = 1'b1;
      bus.if_addr = a;
      if_cur_addr = a;
      e.rdata = hang ? if_last : model_read(a);
      if_last = e.rdata;
      if_q.push_back(e);
    end else begin
      bus.dm_req   = 1'b1;
      bus.dm_we    = we;
      bus.dm_addr  = a;
      bus.dm_wdata = d;
      dm_cur_addr  = a;
      dm_cur_we    = we;
      dm_cur_wdata = d;
      dm_active    = 1'b1;
      if (hang || we) e.rdata = dm_last;
      else            e.rdata = model_read(a);
      if (!hang && we) model_mem[a] = d;
      dm_last = e.rdata;
      dm_q.push_back(e);
    end
  endtask

  task automatic waitAck(input int who, input bit keep, output int n);
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if ((who == REQ_IF) ? bus.if_ack : bus.dm_ack) break;
      n++;
      if (n >= 64) begin
        flag_fail((who == REQ_IF) ? "if_ack_wait_expired" : "dm_ack_wait_expired");
        break;
      end
    end
    if (!keep) begin
      if (who == REQ_IF) bus.if_req = 1'b0;
      else begin
        bus.dm_req = 1'b0;
        dm_active  = 1'b0;
      end
    end
  endtask

  // MIO memory responder with configurable wait states
  initial begin : responder
    int busy_cnt;
    int wait_cyc;
    bit is_dm;
    busy_cnt = 0;
    wait_cyc = 0;
    is_dm = 1'b0;
    bus.MIO_ready = 1'b0;
    bus.Data_in   = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.MIO_ready = 1'b0;
      bus.Data_in   = $urandom;
      if (reset || !bus.CPU_MIO) begin
        busy_cnt = 0;
        if (noise && !reset) bus.MIO_ready = ($urandom_range(0, 3) == 0);
      end else begin
        busy_cnt++;
        if (busy_cnt == 1) begin
          is_dm = dm_active && (bus.Addr_out == dm_cur_addr);
          wait_cyc = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        checkOutput("bus_addr", bus.Addr_out, is_dm ? dm_cur_addr : if_cur_addr);
        checkOutput("bus_mem_w", 32'(bus.mem_w), is_dm ? 32'(dm_cur_we) : 32'd0);
        if (is_dm) checkOutput("bus_wdata", bus.Data_out, dm_cur_wdata);
        if (!hang && busy_cnt == wait_cyc + 1) begin
          bus.MIO_ready = 1'b1;
          if (bus.mem_w) bus_mem[bus.Addr_out[11:2]] = bus.Data_out;
          else           bus.Data_in = bus_mem[bus.Addr_out[11:2]];
        end
      end
    end
  end

  // Scoreboard monitor: pops and compares on every ack
  initial begin : monitor
    logic prev_if, prev_dm;
    exp_t e;
    prev_if = 1'b0;
    prev_dm = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_if = 1'b0;
        prev_dm = 1'b0;
      end else begin
        if (bus.if_ack && bus.dm_ack) flag_fail("ack_overlap");
        if (bus.if_ack) begin
          if (prev_if) flag_fail("if_ack_width");
          if (if_q.size() == 0) flag_fail("if_ack_unexpected");
          else begin
            e = if_q.pop_front();
            checkOutput("if_rdata", bus.if_rdata, e.rdata);
            checkOutput("if_bus_err", 32'(bus.bus_err), 32'(e.err));
          end
        end
        if (bus.dm_ack) begin
          if (prev_dm) flag_fail("dm_ack_width");
          if (dm_q.size() == 0) flag_fail("dm_ack_unexpected");
          else begin
            e = dm_q.pop_front();
            checkOutput("dm_rdata", bus.dm_rdata, e.rdata);
            checkOutput("dm_bus_err", 32'(bus.bus_err), 32'(e.err));
          end
        end
        if (!bus.if_ack && !bus.dm_ack) checkOutput("bus_err_no_ack", 32'(bus.bus_err), 32'd0);
        prev_if = bus.if_ack;
        prev_dm = bus.dm_ack;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : main
    int n;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.dm_req = 1'b0;
    bus.dm_we = 1'b0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    for (int i = 0; i < 1024; i++) bus_mem[i] = init_word(32'(i) << 2);
    bus_mem[1] = 32'h2011_0001;
    model_mem[32'h4] = 32'h2011_0001;

    // Reset state
    #1 reset = 1'b1;
    #2;
    checkOutput("rst_cpu_mio", 32'(bus.CPU_MIO), 32'd0);
    checkOutput("rst_mem_w", 32'(bus.mem_w), 32'd0);
    checkOutput("rst_addr", bus.Addr_out, 32'd0);
    checkOutput("rst_data_out", bus.Data_out, 32'd0);
    checkOutput("rst_if_rdata", bus.if_rdata, 32'd0);
    checkOutput("rst_dm_rdata", bus.dm_rdata, 32'd0);
    checkOutput("rst_acks", {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    checkOutput("rst_bus_err", 32'(bus.bus_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(2);

    // Single fetch with a zero-wait bus
    fixed_wait = 0;
    applyStimulus(REQ_IF, 1'b0, 32'h0000_0004, '0);
    idle(1);
    checkOutput("fetch_cpu_mio", 32'(bus.CPU_MIO), 32'd1);
    checkOutput("fetch_addr", bus.Addr_out, 32'h4);
    checkOutput("fetch_mem_w", 32'(bus.mem_w), 32'd0);
    waitAck(REQ_IF, 1'b0, n);
    checkOutput("fetch_ack_latency", 32'(n), 32'd0);
    checkOutput("fetch_cpu_mio_drop", 32'(bus.CPU_MIO), 32'd0);
    idle(2);

    // Store with three wait cycles
    fixed_wait = 3;
    applyStimulus(REQ_DM, 1'b1, 32'h10, 32'h7);
    idle(1);
    checkOutput("store_mem_w", 32'(bus.mem_w), 32'd1);
    checkOutput("store_data_out", bus.Data_out, 32'h7);
    waitAck(REQ_DM, 1'b0, n);
    checkOutput("store_ack_latency", 32'(n), 32'd3);
    checkOutput("store_mem_w_drop", 32'(bus.mem_w), 32'd0);
    checkOutput("store_cpu_mio_drop", 32'(bus.CPU_MIO), 32'd0);
    idle(2);

    // Simultaneous requests: data first, then fetch
    fixed_wait = 1;
    applyStimulus(REQ_DM, 1'b0, 32'h20, '0);
    applyStimulus(REQ_IF, 1'b0, 32'h40, '0);
    idle(1);
    checkOutput("both_first_addr", bus.Addr_out, 32'h20);
    checkOutput("both_first_mem_w", 32'(bus.mem_w), 32'd0);
    waitAck(REQ_DM, 1'b0, n);
    idle(1);
    checkOutput("both_second_cpu_mio", 32'(bus.CPU_MIO), 32'd1);
    checkOutput("both_second_addr", bus.Addr_out, 32'h40);
    waitAck(REQ_IF, 1'b0, n);
    idle(2);

    // Back-to-back fetches with req held across the ack
    fixed_wait = 0;
    applyStimulus(REQ_IF, 1'b0, 32'h100, '0);
    waitAck(REQ_IF, 1'b1, n);
    applyStimulus(REQ_IF, 1'b0, 32'h104, '0);
    idle(1);
    checkOutput("b2b_bubble", 32'(bus.CPU_MIO), 32'd0);
    idle(1);
    checkOutput("b2b_regrant", 32'(bus.CPU_MIO), 32'd1);
    checkOutput("b2b_addr", bus.Addr_out, 32'h104);
    waitAck(REQ_IF, 1'b0, n);
    checkOutput("b2b_ack_latency", 32'(n), 32'd0);
    idle(2);

    // Asynchronous reset in the middle of a store
    hang = 1'b1;
    applyStimulus(REQ_DM, 1'b1, 32'h30, 32'h55);
    idle(1);
    #2 reset = 1'b1;
    bus.dm_req = 1'b0;
    dm_active = 1'b0;
    #1;
    checkOutput("arst_cpu_mio", 32'(bus.CPU_MIO), 32'd0);
    checkOutput("arst_mem_w", 32'(bus.mem_w), 32'd0);
    checkOutput("arst_addr", bus.Addr_out, 32'd0);
    dm_q.delete();
    dm_last = '0;
    if_last = '0;
    #2 reset = 1'b0;
    hang = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checkOutput("arst_no_dm_ack", 32'(bus.dm_ack), 32'd0);
      checkOutput("arst_stay_idle", 32'(bus.CPU_MIO), 32'd0);
    end

`ifdef MIO_TIMEOUT_EN
    // Watchdog abort with the bus never answering
    hang = 1'b1;
    applyStimulus(REQ_IF, 1'b0, 32'h200, '0);
    waitAck(REQ_IF, 1'b0, n);
    checkOutput("tmo_ack_latency", 32'(n), 32'd4);
    checkOutput("tmo_cpu_mio_drop", 32'(bus.CPU_MIO), 32'd0);
    hang = 1'b0;
    idle(2);

    // Ready on the limit edge completes normally
    fixed_wait = 3;
    applyStimulus(REQ_DM, 1'b0, 32'h900, '0);
    waitAck(REQ_DM, 1'b0, n);
    checkOutput("tmo_edge_latency", 32'(n), 32'd4);
    idle(2);
`endif

    // Randomized traffic from both requesters
    noise = 1'b1;
    fixed_wait = -1;
    fork
      begin : if_traffic
        bit keep;
        int m;
        keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
          if (!keep) idle($urandom_range(0, 3));
          applyStimulus(REQ_IF, 1'b0, 32'($urandom_range(0, 511)) << 2, '0);
          keep = (i < 39) && ($urandom_range(0, 3) == 0);
          waitAck(REQ_IF, keep, m);
        end
      end
      begin : dm_traffic
        bit keep;
        int m;
        keep = 1'b0;
        for (int i = 0; i < 40; i++) begin
          if (!keep) idle($urandom_range(0, 4));
          applyStimulus(REQ_DM, 1'($urandom_range(0, 1)),
                        32'h800 + (32'($urandom_range(0, 511)) << 2), $urandom);
          keep = (i < 39) && ($urandom_range(0, 3) == 0);
          waitAck(REQ_DM, keep, m);
        end
      end
    join
    noise = 1'b0;
    idle(10);

    checkOutput("if_queue_drained", 32'(if_q.size()), 32'd0);
    checkOutput("dm_queue_drained", 32'(dm_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mio_bus_arbiter.md
Name: mio_bus_arbiter

Overview:
- Shares the CPU's single MIO memory port between the pipeline's instruction-fetch (IF) requester and data-memory (MEM) requester.
- Sequences each access with the MIO_ready handshake and returns read data to the requester.
- Issues a one-cycle ack per completed access; the pipeline stalls the requesting stage until that ack.
- Sits between the SCPU pipeline stages and the external MIO bus (CPU_MIO / Addr_out / Data_out / mem_w / Data_in).

Parameters:
- DATA_W, 32, data and address width.
- TIMEOUT_CYC, 255, maximum busy cycles without MIO_ready before abort (used only with the optional feature).
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  DATA_W  fetch address (PC).
- if_rdata  out  DATA_W  fetched instruction; registered.
- if_ack  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  DATA_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data; registered.
- dm_ack  out  1  one-cycle data completion pulse.
- bus_err  out  1  timeout abort flag, pulses with the ack.
- MIO_ready  in  1  bus completes the current access this cycle.
- Data_in  in  DATA_W  bus read data, valid when MIO_ready = 1.
- CPU_MIO  out  1  bus access in progress.
- mem_w  out  1  bus write strobe.
- Addr_out  out  DATA_W  bus address.
- Data_out  out  DATA_W  bus write data.

Behaviour:
- Reset (asynchronous, immediate, including mid-access):
  - state = IDLE.
  - CPU_MIO, mem_w, if_ack, dm_ack, bus_err = 0.
  - Addr_out, Data_out, if_rdata, dm_rdata = 0.
  - Timeout counter = 0.
  - Any in-flight access is dropped with no ack.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE:
  - A requester whose ack is high this cycle is masked, so a held req is not re-granted.
  - Priority: dm_req over if_req (the older instruction wins).
  - Grant DM: latch dm_addr into Addr_out, dm_wdata into Data_out, dm_we into mem_w; CPU_MIO = 1; go to DM_BUSY.
  - Grant IF: latch if_addr into Addr_out; mem_w = 0; Data_out unchanged; CPU_MIO = 1; go to IF_BUSY.
  - No request: outputs hold, CPU_MIO = 0.
- BUSY states:
  - Addr_out, Data_out and mem_w are stable for the whole access; requester inputs are ignored.
  - MIO_ready = 1 at edge M: the ack rises for cycle M+1.
    - Loads and fetches: Data_in is captured into dm_rdata or if_rdata, valid in cycle M+1.
    - Stores: dm_rdata is unchanged.
    - CPU_MIO and mem_w return to 0 in cycle M+1; state returns to IDLE.
  - MIO_ready is ignored in IDLE.
- Latency:
  - req seen at edge N gives CPU_MIO = 1 from cycle N+1.
  - With MIO_ready = 1 on the first busy cycle, the ack appears at N+2.
  - Minimum request-to-request spacing per requester is 3 cycles (the mask adds the bubble).
- Simultaneous events:
  - Both requests in IDLE: DM is served first; IF is granted in the cycle after dm_ack if dm_req has dropped.
  - A new dm_req during IF_BUSY waits; no preemption.
- Requester protocol violations: a req dropped before its ack still completes the access and still pulses the ack.
- Ack pulses are exactly one cycle wide; if_ack and dm_ack are never high together.

Optional Feature:
- Macro: MIO_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to a BUSY state and increments each busy cycle with MIO_ready = 0.
  - When the count reaches TIMEOUT_CYC, the access aborts: the ack pulses together with bus_err = 1, rdata is unchanged, CPU_MIO and mem_w drop, state returns to IDLE.
  - MIO_ready on the same edge as the limit wins: normal completion, bus_err = 0.
- Undefined:
  - No counter logic; bus_err is tied to 0.
  - A BUSY state waits indefinitely for MIO_ready.

Decomposition:
- Package mio_arb_pkg:
  - State encoding constants: IDLE = 2'd0, IF_BUSY = 2'd1, DM_BUSY = 2'd2.
  - Default TIMEOUT_CYC and CNT_W.
  - Requester index constants.
- Sub-module mio_wdog_cnt: clear / enable / limit-reached counter, instantiated only under MIO_TIMEOUT_EN.

Test Plan:
- Reset, then one fetch:
  - Stimulus: if_req = 1, if_addr = 32'h0000_0004; MIO_ready = 1 one cycle after CPU_MIO rises; Data_in = 32'h2011_0001.
  - Response: Addr_out = 4, mem_w = 0; if_ack one cycle; if_rdata = 32'h2011_0001.
- Store with 3 wait cycles:
  - Stimulus: dm_req = 1, dm_we = 1, dm_addr = 32'h10, dm_wdata = 32'h7.
  - Response: mem_w = 1 and Data_out = 7 held 4 busy cycles; dm_ack; dm_rdata stays 0.
- Simultaneous requests:
  - Stimulus: if_req and a load dm_req (dm_addr = 32'h20) in the same cycle.
  - Response: DM served first (Addr_out = 32'h20), then IF after the masked bubble; acks never overlap.
- Async reset mid-access:
  - Stimulus: reset pulsed in DM_BUSY between clock edges.
  - Response: CPU_MIO, mem_w and Addr_out go to 0 immediately; no dm_ack after release.
- Back-to-back fetch with req held:
  - Stimulus: if_req held high across if_ack.
  - Response: second grant exactly 1 cycle after the ack; one ack per access.
- Timeout (MIO_TIMEOUT_EN, TIMEOUT_CYC = 4):
  - Stimulus: MIO_ready held 0 during an access.
  - Response: ack and bus_err pulse after 4 busy cycles; CPU_MIO drops.
  - Repeat with MIO_ready = 1 on the limit edge: bus_err = 0.
